mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 50, number of implemented memory words.
REQ-002 SHALL have parameter ADDR_W, default 6, memory word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid  input  1 and req_ready  output  1: request handshake.
REQ-006 SHALL have ports req_write  input  1 (1=store), req_addr  input  ADDR_W+2 (byte address), req_size  input  2 (00 byte, 01 half, 10 word), req_signed  input  1 (sign-extend subword loads), req_wdata  input  32.
REQ-007 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_rdata  output  32, rsp_err  output  1.
REQ-008 SHALL have ports mem_address  output  ADDR_W, mem_writeData  output  32, mem_memwrite  output  1, mem_memread  output  1, mem_out32  input  32, connecting to the synchronous word memory (registered read, 1-cycle latency).

Function
REQ-009 SHALL implement FSM states IDLE, READ, CAPTURE, MERGE_WR, WRITE, RESP.
REQ-010 SHALL drive req_ready=1 only in IDLE; a request is accepted at the edge where req_valid&&req_ready.
REQ-011 SHALL register word index req_addr[ADDR_W+1:2], byte lane req_addr[1:0], size, signed and wdata on acceptance.
REQ-012 SHALL flag error if index>=MEM_WORDS, word access with lane!=0, halfword with lane[0]=1, or req_size=11; error goes IDLE->RESP with rsp_err=1, rsp_rdata=0, no memory strobe.
REQ-013 Word store: IDLE->WRITE (mem_memwrite=1 one cycle, mem_writeData=wdata)->RESP; rsp_valid high from 2nd edge after acceptance.
REQ-014 Load: IDLE->READ (mem_memread=1 one cycle)->CAPTURE (rsp_rdata<=aligned mem_out32)->RESP; rsp_valid high from 3rd edge after acceptance.
REQ-015 Subword load SHALL select lane little-endian (byte lane n = bits 8n+7:8n; half lane 0/2) and zero- or sign-extend per req_signed.
REQ-016 Subword store SHALL read-modify-write: READ->CAPTURE->MERGE_WR (mem_memwrite=1, writeData = mem_out32 with only addressed lane replaced by low bits of wdata)->RESP; rsp_valid high from 4th edge after acceptance; rsp_rdata=0.
REQ-017 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-018 SHALL never assert mem_memread and mem_memwrite in the same cycle; both low in IDLE and RESP.
REQ-019 mem_address SHALL hold the registered index from acceptance until return to IDLE.
REQ-020 Store rsp_rdata SHALL be 0; rsp_err=0 on all successful accesses.

Reset
REQ-021 rst_n low SHALL immediately force state IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_memread=0, mem_memwrite=0, mem_address=0, mem_writeData=0.
REQ-022 Reset mid-operation SHALL abandon the access with no further strobe and no response.

Configuration
REQ-023 Macro MEM_SUBWORD_EN defined: byte/halfword loads and stores per REQ-015/016.
REQ-024 Macro MEM_SUBWORD_EN undefined: req_size other than 10 SHALL produce error response per REQ-012; MERGE_WR state and lane logic absent.

Structure
REQ-025 Package mem_ctrl_pkg SHALL hold FSM state enum, req_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and default MEM_WORDS.
REQ-026 Combinational sub-module lane_align SHALL implement load extract/extend and store merge.

Verification
REQ-027 Word store 0xDEADBEEF to byte addr 0x10, then word load 0x10 -> mem_memwrite at index 4 one cycle; load rsp_rdata=0xDEADBEEF, rsp_err=0, latency per REQ-013/014.
REQ-028 After REQ-027, signed byte load addr 0x13 -> 0xFFFFFFDE; unsigned half load 0x10 -> 0x0000BEEF.
REQ-029 Byte store 0x55 to addr 0x11 (MEM_SUBWORD_EN) -> one read then one write of 0xDEAD55EF at index 4; word reload returns 0xDEAD55EF.
REQ-030 Word load addr 0xC8 (index 50) and word load addr 0x02 -> rsp_err=1, rsp_rdata=0, no mem strobes.
REQ-031 rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready=0; rst_n pulsed low during READ -> strobes drop immediately, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and encodings for the memory access controller.
package mem_ctrl_pkg;

  localparam int DEF_MEM_WORDS = 50;
  localparam int NUM_LANES     = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE, READ, CAPTURE, MERGE_WR, WRITE, RESP
  } state_t;

endpackage

// File: rtl/lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for stores.
module lane_align import mem_ctrl_pkg::*; (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_st_data
);

  logic [NUM_LANES-1:0][7:0] w_bytes;
  logic [NUM_LANES-1:0][7:0] w_merged;
  logic [NUM_LANES-1:0]      w_lane_sel;
  logic [7:0]                w_byte;
  logic [15:0]               w_half;

  assign w_bytes = i_word;

  always_comb begin
    w_byte    = w_bytes[i_lane];
    w_half    = i_lane[1] ? i_word[31:16] : i_word[15:0];
    o_ld_data = i_word;
    case (i_size)
      SZ_BYTE: o_ld_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_ld_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_ld_data = i_word;
    endcase
  end

  always_comb begin
    w_lane_sel = '0;
    case (i_size)
      SZ_BYTE: w_lane_sel[i_lane] = 1'b1;
      SZ_HALF: w_lane_sel[{i_lane[1], 1'b0} +: 2] = 2'b11;
      default: w_lane_sel = '1;
    endcase
  end

  // Each lane picks the wdata byte that lands on it, then keeps or replaces.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0] w_src;
    always_comb begin
      case (i_size)
        SZ_BYTE: w_src = i_wdata[7:0];
        SZ_HALF: w_src = i_wdata[8*(g%2) +: 8];
        default: w_src = i_wdata[8*g +: 8];
      endcase
    end
    assign w_merged[g] = w_lane_sel[g] ? w_src : w_bytes[g];
  end

  assign o_st_data = w_merged;

endmodule

// File: rtl/mem_access_ctrl.sv
// Request/response front end for a synchronous word memory (1-cycle read).
// Define MEM_SUBWORD_EN for byte/halfword loads and read-modify-write stores.
module mem_access_ctrl import mem_ctrl_pkg::*; #(
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writeData,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [31:0]       mem_out32
);

  state_t            r_state, w_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem_wdata;
  logic              r_err;
  logic [ADDR_W-1:0] w_idx;
  logic              w_oob, w_sz_err, w_req_err;
  logic [31:0]       w_ld_data;

  assign w_idx     = req_addr[ADDR_W+1:2];
  assign w_oob     = (32'(w_idx) >= MEM_WORDS);
  assign w_req_err = w_oob | w_sz_err;

`ifdef MEM_SUBWORD_EN
  logic [1:0]  r_lane, r_size;
  logic        r_signed;
  logic [31:0] w_st_data;

  always_comb begin
    case (req_size)
      SZ_WORD: w_sz_err = |req_addr[1:0];
      SZ_HALF: w_sz_err = req_addr[0];
      SZ_BYTE: w_sz_err = 1'b0;
      default: w_sz_err = 1'b1;
    endcase
  end

  lane_align u_lane_align (
    .i_word    (mem_out32),
    .i_lane    (r_lane),
    .i_size    (r_size),
    .i_signed  (r_signed),
    .i_wdata   (r_mem_wdata),
    .o_ld_data (w_ld_data),
    .o_st_data (w_st_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane   <= '0;
      r_size   <= '0;
      r_signed <= 1'b0;
    end else if (r_state == IDLE && req_valid) begin
      r_lane   <= req_addr[1:0];
      r_size   <= req_size;
      r_signed <= req_signed;
    end
  end
`else
  logic w_unused;
  assign w_unused  = req_signed;
  assign w_sz_err  = (req_size != SZ_WORD) | (|req_addr[1:0]);
  assign w_ld_data = mem_out32;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt        = r_state;
    req_ready    = 1'b0;
    mem_memread  = 1'b0;
    mem_memwrite = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)                          w_nxt = RESP;
          else if (req_write && req_size == SZ_WORD) w_nxt = WRITE;
          else                                    w_nxt = READ;
        end
      end
      READ: begin
        mem_memread = 1'b1;
        w_nxt       = CAPTURE;
      end
`ifdef MEM_SUBWORD_EN
      CAPTURE: w_nxt = r_write ? MERGE_WR : RESP;
      MERGE_WR: begin
        mem_memwrite = 1'b1;
        w_nxt        = RESP;
      end
`else
      CAPTURE: w_nxt = RESP;
`endif
      WRITE: begin
        mem_memwrite = 1'b1;
        w_nxt        = RESP;
      end
      RESP:    if (rsp_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // r_mem_wdata first holds the raw store data, then (subword) the merged word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_addr      <= w_idx;
          r_write     <= req_write;
          r_rdata     <= '0;
          r_err       <= w_req_err;
          r_mem_wdata <= req_wdata;
        end
        CAPTURE: begin
          if (!r_write) r_rdata <= w_ld_data;
`ifdef MEM_SUBWORD_EN
          else          r_mem_wdata <= w_st_data;
`endif
        end
        RESP: if (rsp_ready) begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid     = (r_state == RESP);
  assign rsp_rdata     = r_rdata;
  assign rsp_err       = r_err;
  assign mem_address   = r_addr;
  assign mem_writeData = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed bench for mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;
  localparam int AW = 6;
`ifdef MEM_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, rsp_ready = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [1:0] req_size = 2'b10;
  logic [31:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, mem_memwrite, mem_memread;
  logic [31:0] rsp_rdata, mem_writeData, mem_out32;
  logic [AW-1:0] mem_address;

  int n_checks = 0, n_err = 0;

  mem_access_ctrl #(.MEM_WORDS(50), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_out32(mem_out32));

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h13572468;
  endfunction

  // Synchronous memory: registered read, write on strobe.
  logic [31:0] env_mem [64];
  bit mem_inited = 1'b0;
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= init_word(i);
      mem_inited <= 1'b1;
    end else begin
      if (mem_memwrite) env_mem[mem_address] <= mem_writeData;
      mem_out32 <= env_mem[mem_address];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: word store contents plus per-cycle expectations.
  logic [31:0] ref_mem [64];
  typedef struct {
    bit busy, rdy, rd, wr, rv, err;
    logic [31:0] wdata, rdata;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t expq[$];

  function automatic bit m_err(input int idx, input int lane, input logic [1:0] sz);
    if (idx >= 50 || sz == 2'b11) return 1'b1;
    if (sz == 2'b10) return lane != 0;
    if (!SUB) return 1'b1;
    if (sz == 2'b01) return (lane % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input int lane,
                                         input logic [1:0] sz, input bit sg);
    logic [31:0] v;
    if (sz == 2'b10) return w;
    if (sz == 2'b01) begin
      v = (w >> (16 * (lane / 2))) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = (w >> (8 * lane)) & 32'hFF;
      if (sg && v >= 32'h80) v = v - 32'h100;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input int lane,
                                          input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] mask;
    mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
    return (w & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && expq.size() > 0) begin
      e = expq.pop_front();
      chk("req_ready", 32'(req_ready), 32'(e.rdy));
      chk("mem_memread", 32'(mem_memread), 32'(e.rd));
      chk("mem_memwrite", 32'(mem_memwrite), 32'(e.wr));
      chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
      if (e.busy) chk("mem_address", 32'(mem_address), 32'(e.addr));
      if (e.wr) chk("mem_writeData", mem_writeData, e.wdata);
      if (e.rv) begin
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  function automatic exp_t mk(input bit busy, rdy, rd, wr, rv, err,
                              input logic [31:0] wd, rdv, input int idx);
    exp_t e;
    e.busy = busy; e.rdy = rdy; e.rd = rd; e.wr = wr; e.rv = rv; e.err = err;
    e.wdata = wd; e.rdata = rdv; e.addr = AW'(idx);
    return e;
  endfunction

  // Called and returns at posedge+1; hold = cycles rsp_ready stays low in RESP.
  task automatic do_req(input bit wr, input logic [7:0] addr, input logic [1:0] sz,
                        input bit sg, input logic [31:0] wd, input int hold,
                        output logic [31:0] g_rd, output logic g_err);
    int idx, lane, p, j;
    bit err;
    logic [31:0] rexp, wexp;
    idx = int'(addr[7:2]); lane = int'(addr[1:0]);
    err = m_err(idx, lane, sz);
    rexp = 32'h0; wexp = 32'h0;
    g_rd = 32'h0; g_err = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = sz;
    req_signed = sg; req_wdata = wd; rsp_ready = 1'b0;
    expq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    if (err) p = 0;
    else if (!wr) begin
      p = 2;
      rexp = m_load(ref_mem[idx], lane, sz, sg);
      expq.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, idx));
      expq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, idx));
    end else if (sz == 2'b10) begin
      p = 1;
      wexp = wd;
      expq.push_back(mk(1, 0, 0, 1, 0, 0, wexp, 0, idx));
    end else begin
      p = 3;
      wexp = m_merge(ref_mem[idx], lane, sz, wd);
      expq.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, idx));
      expq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, idx));
      expq.push_back(mk(1, 0, 0, 1, 0, 0, wexp, 0, idx));
    end
    if (!err && wr) ref_mem[idx] = wexp;
    for (int k = 0; k <= hold; k++) expq.push_back(mk(1, 0, 0, 0, 1, err, 0, rexp, idx));
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (j = 0; j < p + hold; j++) begin
      if (j == p) begin g_rd = rsp_rdata; g_err = rsp_err; end
      @(posedge clk); #1;
    end
    if (hold == 0) begin g_rd = rsp_rdata; g_err = rsp_err; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic er;

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_strobes", {30'b0, mem_memread, mem_memwrite}, 0);
    chk("rst_mem_address", 32'(mem_address), 0);
    chk("rst_mem_writeData", mem_writeData, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 1);

    do_req(1, 8'h10, 2'b10, 0, 32'hDEADBEEF, 0, rd, er);
    chk("st_word_rdata", rd, 0);
    chk("st_word_err", 32'(er), 0);
    chk("st_word_mem4", env_mem[4], 32'hDEADBEEF);
    do_req(0, 8'h10, 2'b10, 0, 0, 0, rd, er);
    chk("ld_word_rdata", rd, 32'hDEADBEEF);
    chk("ld_word_err", 32'(er), 0);
    do_req(0, 8'h13, 2'b00, 1, 0, 0, rd, er);
    chk("ld_sbyte_rdata", rd, SUB ? 32'hFFFFFFDE : 32'h0);
    chk("ld_sbyte_err", 32'(er), SUB ? 0 : 1);
    do_req(0, 8'h10, 2'b01, 0, 0, 1, rd, er);
    chk("ld_uhalf_rdata", rd, SUB ? 32'h0000BEEF : 32'h0);
    do_req(1, 8'h11, 2'b00, 0, 32'h00000055, 0, rd, er);
    chk("st_byte_err", 32'(er), SUB ? 0 : 1);
    chk("st_byte_mem4", env_mem[4], SUB ? 32'hDEAD55EF : 32'hDEADBEEF);
    do_req(0, 8'h10, 2'b10, 0, 0, 0, rd, er);
    chk("reload_rdata", rd, SUB ? 32'hDEAD55EF : 32'hDEADBEEF);
    do_req(0, 8'hC8, 2'b10, 0, 0, 0, rd, er);
    chk("oob_err", 32'(er), 1);
    chk("oob_rdata", rd, 0);
    do_req(0, 8'h02, 2'b10, 0, 0, 0, rd, er);
    chk("misalign_err", 32'(er), 1);
    chk("misalign_rdata", rd, 0);
    do_req(0, 8'h20, 2'b10, 0, 0, 5, rd, er);
    chk("hold_rdata", rd, ref_mem[8]);

    for (int n = 0; n < 200; n++) begin
      logic [7:0] a;
      a = {6'($urandom_range(0, 55)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      do_req(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom_range(0, 3), rd, er);
      if ($urandom_range(0, 4) == 0) begin
        expq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
      end
    end

    // Reset while in READ abandons the load.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h1C; req_size = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid_read", 32'(mem_memread), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {30'b0, mem_memread, mem_memwrite}, 0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("post_rst_strobes", {30'b0, mem_memread, mem_memwrite}, 0);
      chk("post_rst_req_ready", 32'(req_ready), 1);
    end
    @(posedge clk); #1;
    do_req(0, 8'h1C, 2'b10, 0, 0, 0, rd, er);
    chk("post_rst_load", rd, ref_mem[7]);
    repeat (2) @(posedge clk);
    if (expq.size() != 0) chk("exp_queue_drained", 32'(expq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
